// File: rtl/cpu1_seq_if.sv
// Bus between the CPU1 sequencer and its ROM/datapath neighbours.
// Signal suffixes are named from the sequencer's point of view.
interface cpu1_seq_if #(
  parameter int AW  = 4,
  parameter int OPW = 4
);
  logic                run_i;
  logic [OPW+AW-1:0]   instr_i;
  logic                zero_i;
  logic                carry_i;
  logic                pc_en_o;
  logic                jump_o;
  logic [AW-1:0]       jump_v_o;
  logic                ir_ld_o;
  logic                acc_ld_o;
  logic [1:0]          alu_op_o;
  logic [AW-1:0]       imm_o;
  logic                out_ld_o;
  logic                halted_o;
  logic [1:0]          state_o;

  modport slave (
    input  run_i, instr_i, zero_i, carry_i,
    output pc_en_o, jump_o, jump_v_o, ir_ld_o, acc_ld_o, alu_op_o,
           imm_o, out_ld_o, halted_o, state_o
  );

  modport master (
    output run_i, instr_i, zero_i, carry_i,
    input  pc_en_o, jump_o, jump_v_o, ir_ld_o, acc_ld_o, alu_op_o,
           imm_o, out_ld_o, halted_o, state_o
  );
endinterface

// File: rtl/cpu1_seq.sv
// CPU1 instruction sequencer: two-cycle fetch/execute FSM that latches the
// instruction word and decodes it into PC, accumulator, ALU and output strobes.
module cpu1_seq #(
  parameter int AW  = 4,
  parameter int OPW = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  cpu1_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    EXEC  = 2'b10,
    HALT  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    J_NONE = 2'b00,
    J_ALW  = 2'b01,
    J_Z    = 2'b10,
    J_C    = 2'b11
  } jkind_t;

  localparam logic [OPW-1:0] OP_LDA = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD = OPW'(2);
  localparam logic [OPW-1:0] OP_SUB = OPW'(3);
  localparam logic [OPW-1:0] OP_JMP = OPW'(4);
  localparam logic [OPW-1:0] OP_JZ  = OPW'(5);
  localparam logic [OPW-1:0] OP_JC  = OPW'(6);
  localparam logic [OPW-1:0] OP_OUT = OPW'(7);
  localparam logic [OPW-1:0] OP_HLT = OPW'(15);

  state_t              state_q;
  jkind_t              jkind_q;
  logic [OPW+AW-1:0]   ir_q;
  logic                pc_en_q;
  logic                ir_ld_q;
  logic                acc_ld_q;
  logic [1:0]          alu_op_q;
  logic                out_ld_q;
  logic                halted_q;

  logic [OPW-1:0]      op_fetch;
  logic [OPW-1:0]      op_exec;
  logic                jump_take;

  assign op_fetch = bus.instr_i[OPW+AW-1 -: OPW];
  assign op_exec  = ir_q[OPW+AW-1 -: OPW];

  // Strobes are decoded one cycle early from the ROM word so they are
  // registered in EXEC; only the flag qualification of JZ/JC stays
  // combinational because the flags must be sampled during EXEC itself.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      jkind_q  <= J_NONE;
      ir_q     <= '0;
      pc_en_q  <= 1'b0;
      ir_ld_q  <= 1'b0;
      acc_ld_q <= 1'b0;
      alu_op_q <= 2'b00;
      out_ld_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      pc_en_q  <= 1'b0;
      ir_ld_q  <= 1'b0;
      acc_ld_q <= 1'b0;
      alu_op_q <= 2'b00;
      out_ld_q <= 1'b0;
      jkind_q  <= J_NONE;
      unique case (state_q)
        IDLE: begin
          if (bus.run_i) begin
            state_q <= FETCH;
            pc_en_q <= 1'b1;
            ir_ld_q <= 1'b1;
          end
        end
        FETCH: begin
          ir_q    <= bus.instr_i;
          state_q <= EXEC;
          case (op_fetch)
            OP_LDA: begin acc_ld_q <= 1'b1; alu_op_q <= 2'b00; end
            OP_ADD: begin acc_ld_q <= 1'b1; alu_op_q <= 2'b01; end
            OP_SUB: begin acc_ld_q <= 1'b1; alu_op_q <= 2'b10; end
            OP_JMP: jkind_q  <= J_ALW;
            OP_JZ:  jkind_q  <= J_Z;
            OP_JC:  jkind_q  <= J_C;
            OP_OUT: out_ld_q <= 1'b1;
            default: ;
          endcase
        end
        EXEC: begin
          if (op_exec == OP_HLT) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end else if (bus.run_i) begin
            state_q <= FETCH;
            pc_en_q <= 1'b1;
            ir_ld_q <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        HALT: ;
      endcase
    end
  end

  assign jump_take = (jkind_q == J_ALW)
                   | ((jkind_q == J_Z) & bus.zero_i)
                   | ((jkind_q == J_C) & bus.carry_i);

  assign bus.pc_en_o  = pc_en_q | jump_take;
  assign bus.jump_o   = jump_take;
  assign bus.jump_v_o = jump_take ? ir_q[AW-1:0] : '0;
  assign bus.ir_ld_o  = ir_ld_q;
  assign bus.acc_ld_o = acc_ld_q;
  assign bus.alu_op_o = alu_op_q;
  assign bus.imm_o    = ir_q[AW-1:0];
  assign bus.out_ld_o = out_ld_q;
  assign bus.halted_o = halted_q;
  assign bus.state_o  = state_q;

endmodule
